// File: rtl/ddr_request_arbiter.sv
// ---------------------------------------------------------------------------
// ddr_request_arbiter
//   Front-end request arbiter for the Ddr controller (clk133_p domain).
//   It merges video read requests (vid) and graphics write requests (gfx)
//   into one Ddr command stream. Video has priority. Graphics cannot starve:
//   after MAX_STREAK video grants in a row while gfx waits, gfx wins the next
//   slot. The block counts read bursts that have been issued but not yet
//   returned, and passes returned read data back to the video port.
//
// Ports
//   clk133_p    in   single clock, rising edge
//   rst         in   asynchronous, active-high reset
//   vid_req     in   read request, held with vid_addr until vid_ack
//   vid_addr    in   read burst address {row, bank, col}, col[0]=0
//   vid_ack     out  read request accepted (combinational)
//   vid_rvalid  out  one-cycle pulse, vid_rdata valid
//   vid_rdata   out  returned read burst (holds between pulses)
//   gfx_req     in   write request, held with gfx_addr/gfx_wdata until gfx_ack
//   gfx_addr    in   write burst address
//   gfx_wdata   in   write burst data (beat0 in [15:0])
//   gfx_ack     out  write request accepted (combinational)
//   cmd_valid   out  command to Ddr valid
//   cmd_write   out  1 = write, 0 = read
//   cmd_addr    out  command address
//   cmd_wdata   out  write data (zero for reads)
//   cmd_ready   in   Ddr accepts the command this cycle
//   rd_valid    in   Ddr read burst return, in issue order
//   rd_data     in   Ddr read burst data
//   rd_err      out  sticky: a read return arrived with nothing outstanding
// ---------------------------------------------------------------------------
module ddr_request_arbiter #(
   parameter int ADDR_W          = 25,
   parameter int DATA_W          = 32,
   parameter int MAX_STREAK      = 4,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic              clk133_p,
   input  logic              rst,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic              vid_ack,
   output logic              vid_rvalid,
   output logic [DATA_W-1:0] vid_rdata,
   input  logic              gfx_req,
   input  logic [ADDR_W-1:0] gfx_addr,
   input  logic [DATA_W-1:0] gfx_wdata,
   output logic              gfx_ack,
   output logic              cmd_valid,
   output logic              cmd_write,
   output logic [ADDR_W-1:0] cmd_addr,
   output logic [DATA_W-1:0] cmd_wdata,
   input  logic              cmd_ready,
   input  logic              rd_valid,
   input  logic [DATA_W-1:0] rd_data,
   output logic              rd_err
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int STK_W = $clog2(MAX_STREAK + 1);

   localparam logic [CNT_W-1:0] OUT_MAX = CNT_W'(MAX_OUTSTANDING);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [STK_W-1:0] STK_MAX = STK_W'(MAX_STREAK);
   localparam logic [STK_W-1:0] STK_ONE = STK_W'(1);
   localparam logic [STK_W-1:0] STK_ZERO = STK_W'(0);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_ISSUE = 1'b1;

   localparam logic GNT_VID = 1'b0;
   localparam logic GNT_GFX = 1'b1;

   logic [0:0]        state_q, state_d;
   logic              grant_q, grant_d;
   logic              cmd_valid_q, cmd_valid_d;
   logic              cmd_write_q, cmd_write_d;
   logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
   logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
   logic [STK_W-1:0]  streak_q, streak_d;
   logic [CNT_W-1:0]  outst_q, outst_d;
   logic              rd_err_q, rd_err_d;
   logic              vid_rvalid_q, vid_rvalid_d;
   logic [DATA_W-1:0] vid_rdata_q, vid_rdata_d;

   logic elig_vid_s, elig_gfx_s, pick_gfx_s, pick_vid_s, handshake_s, read_hs_s;

   // Arbitration terms: video is held off once the read-return window is full.
   always_comb begin
      elig_vid_s  = vid_req & (outst_q < OUT_MAX);
      elig_gfx_s  = gfx_req;
      pick_gfx_s  = elig_gfx_s & (~elig_vid_s | (streak_q == STK_MAX));
      pick_vid_s  = elig_vid_s & ~pick_gfx_s;
      handshake_s = cmd_valid_q & cmd_ready;
      read_hs_s   = handshake_s & ~cmd_write_q;
   end

   assign vid_ack = handshake_s & (grant_q == GNT_VID);
   assign gfx_ack = handshake_s & (grant_q == GNT_GFX);

   // Command FSM: latch the winner in IDLE, hold it in ISSUE until accepted.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      cmd_valid_d = cmd_valid_q;
      cmd_write_d = cmd_write_q;
      cmd_addr_d  = cmd_addr_q;
      cmd_wdata_d = cmd_wdata_q;
      streak_d    = streak_q;
      case (state_q)
         S_IDLE: begin
            if (pick_gfx_s) begin
               grant_d     = GNT_GFX;
               cmd_valid_d = 1'b1;
               cmd_write_d = 1'b1;
               cmd_addr_d  = gfx_addr;
               cmd_wdata_d = gfx_wdata;
               state_d     = S_ISSUE;
            end else if (pick_vid_s) begin
               grant_d     = GNT_VID;
               cmd_valid_d = 1'b1;
               cmd_write_d = 1'b0;
               cmd_addr_d  = vid_addr;
               cmd_wdata_d = {DATA_W{1'b0}};
               state_d     = S_ISSUE;
            end else begin
               state_d = S_IDLE;
            end
            // The streak only counts video wins that actually made gfx wait.
            if (!gfx_req || pick_gfx_s) begin
               streak_d = STK_ZERO;
            end else if (pick_vid_s && (streak_q != STK_MAX)) begin
               streak_d = streak_q + STK_ONE;
            end else begin
               streak_d = streak_q;
            end
         end
         S_ISSUE: begin
            if (handshake_s) begin
               cmd_valid_d = 1'b0;
               state_d     = S_IDLE;
            end else begin
               state_d = S_ISSUE;
            end
         end
         default: begin
            cmd_valid_d = 1'b0;
            state_d     = S_IDLE;
         end
      endcase
   end

   // Outstanding-read bookkeeping, error flag and return-data path.
   always_comb begin
      outst_d = outst_q;
      if (read_hs_s && !rd_valid) begin
         outst_d = outst_q + CNT_ONE;
      end else if (!read_hs_s && rd_valid && (outst_q != CNT_ZERO)) begin
         outst_d = outst_q - CNT_ONE;
      end else begin
         outst_d = outst_q;
      end
      rd_err_d     = rd_err_q | (rd_valid & (outst_q == CNT_ZERO));
      vid_rvalid_d = rd_valid;
      if (rd_valid) begin
         vid_rdata_d = rd_data;
      end else begin
         vid_rdata_d = vid_rdata_q;
      end
   end

   // State registers; reset drops any in-flight command immediately.
   always_ff @(posedge clk133_p or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         grant_q      <= GNT_VID;
         cmd_valid_q  <= 1'b0;
         cmd_write_q  <= 1'b0;
         cmd_addr_q   <= {ADDR_W{1'b0}};
         cmd_wdata_q  <= {DATA_W{1'b0}};
         streak_q     <= STK_ZERO;
         outst_q      <= CNT_ZERO;
         rd_err_q     <= 1'b0;
         vid_rvalid_q <= 1'b0;
         vid_rdata_q  <= {DATA_W{1'b0}};
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         cmd_valid_q  <= cmd_valid_d;
         cmd_write_q  <= cmd_write_d;
         cmd_addr_q   <= cmd_addr_d;
         cmd_wdata_q  <= cmd_wdata_d;
         streak_q     <= streak_d;
         outst_q      <= outst_d;
         rd_err_q     <= rd_err_d;
         vid_rvalid_q <= vid_rvalid_d;
         vid_rdata_q  <= vid_rdata_d;
      end
   end

   assign cmd_valid  = cmd_valid_q;
   assign cmd_write  = cmd_write_q;
   assign cmd_addr   = cmd_addr_q;
   assign cmd_wdata  = cmd_wdata_q;
   assign rd_err     = rd_err_q;
   assign vid_rvalid = vid_rvalid_q;
   assign vid_rdata  = vid_rdata_q;

endmodule

// File: tb/tb_ddr_request_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ddr_request_arbiter
//   Scenario tasks drive the arbiter. Expected commands and expected read
//   returns are pushed to queues as stimulus is applied, then popped and
//   compared when the arbiter hands over a command or returns read data.
// ---------------------------------------------------------------------------
module tb_ddr_request_arbiter;

   localparam int AW = 25;
   localparam int DW = 32;

   logic          clk133_p = 1'b0;
   logic          rst;
   logic          vid_req;
   logic [AW-1:0] vid_addr;
   logic          vid_ack;
   logic          vid_rvalid;
   logic [DW-1:0] vid_rdata;
   logic          gfx_req;
   logic [AW-1:0] gfx_addr;
   logic [DW-1:0] gfx_wdata;
   logic          gfx_ack;
   logic          cmd_valid;
   logic          cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          cmd_ready;
   logic          rd_valid;
   logic [DW-1:0] rd_data;
   logic          rd_err;

   ddr_request_arbiter dut (
      .clk133_p  (clk133_p),
      .rst       (rst),
      .vid_req   (vid_req),
      .vid_addr  (vid_addr),
      .vid_ack   (vid_ack),
      .vid_rvalid(vid_rvalid),
      .vid_rdata (vid_rdata),
      .gfx_req   (gfx_req),
      .gfx_addr  (gfx_addr),
      .gfx_wdata (gfx_wdata),
      .gfx_ack   (gfx_ack),
      .cmd_valid (cmd_valid),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .cmd_ready (cmd_ready),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data),
      .rd_err    (rd_err)
   );

   always #4 clk133_p = ~clk133_p;

   int checks = 0;
   int errors = 0;

   // {write, addr, wdata}
   logic [AW+DW:0] cmdq[$];
   logic [DW-1:0]  rdq[$];

   task automatic tick();
      @(posedge clk133_p);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; vid_req = 1'b0; vid_addr = '0; gfx_req = 1'b0; gfx_addr = '0;
      gfx_wdata = '0; cmd_ready = 1'b0; rd_valid = 1'b0; rd_data = '0;
      tick(); tick(); #1;
      checks++;
      if ({cmd_valid, cmd_write, cmd_addr, cmd_wdata, vid_rvalid, vid_rdata, rd_err, vid_ack, gfx_ack} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: valid=%0b write=%0b addr=%h wdata=%h rvalid=%0b rdata=%h err=%0b acks=%0b%0b, required all 0",
                  cmd_valid, cmd_write, cmd_addr, cmd_wdata, vid_rvalid, vid_rdata, rd_err, vid_ack, gfx_ack);
      end
      rst = 1'b0;
      tick(); tick(); #1;
      checks++;
      if ({cmd_valid, cmd_write, cmd_addr, cmd_wdata, vid_rvalid, vid_rdata, rd_err, vid_ack, gfx_ack} !== '0) begin
         errors++;
         $display("FAIL idle_outputs: valid=%0b addr=%h err=%0b, required all 0", cmd_valid, cmd_addr, rd_err);
      end
   endtask

   task automatic test_vid_basic();
      logic [AW+DW:0] e;
      logic [DW-1:0]  r;
      cmdq.push_back({1'b0, 25'h0000010, 32'h0});
      vid_req = 1'b1; vid_addr = 25'h0000010;
      tick(); #1;
      checks++;
      if (!(cmd_valid === 1'b1 && cmd_write === 1'b0 && cmd_addr === 25'h0000010 && vid_ack === 1'b0)) begin
         errors++;
         $display("FAIL vid_issue: valid=%0b write=%0b addr=%h ack=%0b, required 1 0 0000010 0",
                  cmd_valid, cmd_write, cmd_addr, vid_ack);
      end
      cmd_ready = 1'b1; #1;
      checks++;
      if (!(vid_ack === 1'b1 && gfx_ack === 1'b0)) begin
         errors++;
         $display("FAIL vid_ack: vid_ack=%0b gfx_ack=%0b, required 1 0", vid_ack, gfx_ack);
      end
      checks++;
      e = cmdq.pop_front();
      if ({cmd_write, cmd_addr, cmd_wdata} !== e) begin
         errors++;
         $display("FAIL vid_cmd_sb: got %h, required %h", {cmd_write, cmd_addr, cmd_wdata}, e);
      end
      tick(); vid_req = 1'b0; cmd_ready = 1'b0; #1;
      checks++;
      if (cmd_valid !== 1'b0 || vid_ack !== 1'b0) begin
         errors++;
         $display("FAIL vid_drop: valid=%0b ack=%0b, required 0 0", cmd_valid, vid_ack);
      end
      rdq.push_back(32'hCAFE0001);
      rd_valid = 1'b1; rd_data = 32'hCAFE0001;
      tick(); rd_valid = 1'b0; rd_data = 32'hDEADBEEF; #1;
      checks++;
      r = rdq.pop_front();
      if (vid_rvalid !== 1'b1 || vid_rdata !== r) begin
         errors++;
         $display("FAIL vid_return: rvalid=%0b rdata=%h, required 1 %h", vid_rvalid, vid_rdata, r);
      end
      tick(); #1;
      checks++;
      if (vid_rvalid !== 1'b0 || vid_rdata !== 32'hCAFE0001) begin
         errors++;
         $display("FAIL rdata_hold: rvalid=%0b rdata=%h, required 0 cafe0001", vid_rvalid, vid_rdata);
      end
   endtask

   task automatic test_gfx_stall();
      logic [AW+DW:0] e;
      cmdq.push_back({1'b1, 25'h1ABCDE0, 32'hAAAA5555});
      gfx_req = 1'b1; gfx_addr = 25'h1ABCDE0; gfx_wdata = 32'hAAAA5555; cmd_ready = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (!(cmd_valid === 1'b1 && cmd_write === 1'b1 && cmd_addr === 25'h1ABCDE0 &&
               cmd_wdata === 32'hAAAA5555 && gfx_ack === 1'b0)) begin
            errors++;
            $display("FAIL gfx_stall cycle %0d: valid=%0b write=%0b addr=%h wdata=%h ack=%0b, required 1 1 1abcde0 aaaa5555 0",
                     i, cmd_valid, cmd_write, cmd_addr, cmd_wdata, gfx_ack);
         end
         tick();
      end
      cmd_ready = 1'b1; #1;
      checks++;
      if (!(gfx_ack === 1'b1 && vid_ack === 1'b0)) begin
         errors++;
         $display("FAIL gfx_ack: gfx_ack=%0b vid_ack=%0b, required 1 0", gfx_ack, vid_ack);
      end
      checks++;
      e = cmdq.pop_front();
      if ({cmd_write, cmd_addr, cmd_wdata} !== e) begin
         errors++;
         $display("FAIL gfx_cmd_sb: got %h, required %h", {cmd_write, cmd_addr, cmd_wdata}, e);
      end
      tick(); gfx_req = 1'b0; cmd_ready = 1'b0; #1;
      checks++;
      if (cmd_valid !== 1'b0) begin
         errors++;
         $display("FAIL gfx_drop: valid=%0b, required 0", cmd_valid);
      end
   endtask

   task automatic test_streak();
      logic [AW+DW:0] e;
      logic [DW-1:0]  r;
      bit             exp_g[10];
      int             n;
      bit             pend;
      exp_g = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 10; i++) begin
         if (exp_g[i]) cmdq.push_back({1'b1, 25'h0123450, 32'h0F0F1234});
         else          cmdq.push_back({1'b0, 25'h0000040, 32'h0});
      end
      vid_req = 1'b1; vid_addr = 25'h0000040;
      gfx_req = 1'b1; gfx_addr = 25'h0123450; gfx_wdata = 32'h0F0F1234;
      cmd_ready = 1'b1;
      n = 0; pend = 1'b0;
      for (int cyc = 0; cyc < 80 && n < 10; cyc++) begin
         rd_valid = pend;
         rd_data  = 32'h50000000 + 32'(cyc);
         if (pend) rdq.push_back(rd_data);
         pend = 1'b0;
         #1;
         if (vid_rvalid) begin
            checks++;
            r = rdq.pop_front();
            if (vid_rdata !== r) begin
               errors++;
               $display("FAIL streak_return: rdata=%h, required %h", vid_rdata, r);
            end
         end
         if (cmd_valid) begin
            checks++;
            e = cmdq.pop_front();
            if ({cmd_write, cmd_addr, cmd_wdata} !== e) begin
               errors++;
               $display("FAIL grant_seq[%0d]: write=%0b addr=%h, required write=%0b (%h)",
                        n, cmd_write, cmd_addr, exp_g[n], e);
            end
            if (!cmd_write) pend = 1'b1;
            n++;
         end
         tick();
      end
      vid_req = 1'b0; gfx_req = 1'b0; cmd_ready = 1'b0; rd_valid = 1'b0;
      checks++;
      if (n != 10) begin
         errors++;
         $display("FAIL streak_timeout: grants=%0d, required 10", n);
      end
   endtask

   task automatic test_outstanding_limit();
      logic [AW+DW:0] e;
      logic [DW-1:0]  r;
      int             hs;
      bit             found;
      for (int i = 0; i < 4; i++) cmdq.push_back({1'b0, 25'h0000100, 32'h0});
      vid_req = 1'b1; vid_addr = 25'h0000100; cmd_ready = 1'b1;
      hs = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         #1;
         if (cmd_valid && cmd_ready) begin
            hs++;
            checks++;
            if (cmdq.size() == 0) begin
               errors++;
               $display("FAIL limit_cmd_sb: unexpected read addr=%h", cmd_addr);
            end else begin
               e = cmdq.pop_front();
               if ({cmd_write, cmd_addr, cmd_wdata} !== e) begin
                  errors++;
                  $display("FAIL limit_cmd_sb: got %h, required %h", {cmd_write, cmd_addr, cmd_wdata}, e);
               end
            end
         end
         tick();
      end
      checks++;
      if (hs != 4 || cmd_valid !== 1'b0) begin
         errors++;
         $display("FAIL read_limit: reads=%0d valid=%0b, required 4 0", hs, cmd_valid);
      end
      cmdq.push_back({1'b0, 25'h0000100, 32'h0});
      rdq.push_back(32'h12345678);
      rd_valid = 1'b1; rd_data = 32'h12345678;
      tick(); rd_valid = 1'b0; #1;
      checks++;
      r = rdq.pop_front();
      if (vid_rvalid !== 1'b1 || vid_rdata !== r) begin
         errors++;
         $display("FAIL limit_return: rvalid=%0b rdata=%h, required 1 %h", vid_rvalid, vid_rdata, r);
      end
      found = 1'b0;
      for (int cyc = 0; cyc < 6 && !found; cyc++) begin
         #1;
         if (cmd_valid && cmd_ready) begin
            found = 1'b1;
            e = cmdq.pop_front();
            checks++;
            if ({cmd_write, cmd_addr, cmd_wdata} !== e) begin
               errors++;
               $display("FAIL fifth_read: got %h, required %h", {cmd_write, cmd_addr, cmd_wdata}, e);
            end
         end
         tick();
      end
      vid_req = 1'b0; cmd_ready = 1'b0;
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL fifth_read_timeout: issued=0, required 1");
      end
   endtask

   task automatic test_same_cycle_and_err();
      logic [AW+DW:0] e;
      logic [DW-1:0]  r;
      int             hs;
      // 4 outstanding -> 3
      rdq.push_back(32'hA1A1A1A1);
      rd_valid = 1'b1; rd_data = 32'hA1A1A1A1;
      tick(); rd_valid = 1'b0; #1;
      checks++;
      r = rdq.pop_front();
      if (vid_rvalid !== 1'b1 || vid_rdata !== r) begin
         errors++;
         $display("FAIL same_pre_return: rvalid=%0b rdata=%h, required 1 %h", vid_rvalid, vid_rdata, r);
      end
      cmdq.push_back({1'b0, 25'h0000200, 32'h0});
      vid_req = 1'b1; vid_addr = 25'h0000200; cmd_ready = 1'b0;
      tick(); #1;
      checks++;
      if (cmd_valid !== 1'b1) begin
         errors++;
         $display("FAIL same_issue: valid=%0b, required 1", cmd_valid);
      end
      cmd_ready = 1'b1; rd_valid = 1'b1; rd_data = 32'hA2A2A2A2;
      rdq.push_back(32'hA2A2A2A2);
      #1;
      checks++;
      e = cmdq.pop_front();
      if (vid_ack !== 1'b1 || {cmd_write, cmd_addr, cmd_wdata} !== e) begin
         errors++;
         $display("FAIL same_handshake: ack=%0b cmd=%h, required 1 %h", vid_ack, {cmd_write, cmd_addr, cmd_wdata}, e);
      end
      tick(); rd_valid = 1'b0; vid_addr = 25'h0000240; #1;
      checks++;
      r = rdq.pop_front();
      if (vid_rvalid !== 1'b1 || vid_rdata !== r) begin
         errors++;
         $display("FAIL same_return: rvalid=%0b rdata=%h, required 1 %h", vid_rvalid, vid_rdata, r);
      end
      // count must still be 3: exactly one more read fits
      cmdq.push_back({1'b0, 25'h0000240, 32'h0});
      hs = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         #1;
         if (cmd_valid && cmd_ready) begin
            hs++;
            checks++;
            if (cmdq.size() == 0) begin
               errors++;
               $display("FAIL same_extra_cmd: unexpected read addr=%h", cmd_addr);
            end else begin
               e = cmdq.pop_front();
               if ({cmd_write, cmd_addr, cmd_wdata} !== e) begin
                  errors++;
                  $display("FAIL same_extra_cmd: got %h, required %h", {cmd_write, cmd_addr, cmd_wdata}, e);
               end
            end
         end
         tick();
      end
      vid_req = 1'b0; cmd_ready = 1'b0;
      checks++;
      if (hs != 1) begin
         errors++;
         $display("FAIL same_cycle_count: extra reads=%0d, required 1", hs);
      end
      for (int i = 0; i < 4; i++) begin
         rd_valid = 1'b1; rd_data = 32'hB0000000 + 32'(i);
         rdq.push_back(rd_data);
         tick(); rd_valid = 1'b0; #1;
         checks++;
         r = rdq.pop_front();
         if (vid_rvalid !== 1'b1 || vid_rdata !== r) begin
            errors++;
            $display("FAIL drain_return[%0d]: rvalid=%0b rdata=%h, required 1 %h", i, vid_rvalid, vid_rdata, r);
         end
      end
      checks++;
      if (rd_err !== 1'b0) begin
         errors++;
         $display("FAIL no_err_after_drain: rd_err=%0b, required 0", rd_err);
      end
      rd_valid = 1'b1; rd_data = 32'hE0E0E0E0;
      rdq.push_back(32'hE0E0E0E0);
      tick(); rd_valid = 1'b0; #1;
      checks++;
      r = rdq.pop_front();
      if (rd_err !== 1'b1 || vid_rvalid !== 1'b1 || vid_rdata !== r) begin
         errors++;
         $display("FAIL rd_err_set: err=%0b rvalid=%0b rdata=%h, required 1 1 %h", rd_err, vid_rvalid, vid_rdata, r);
      end
      tick(); tick(); tick(); #1;
      checks++;
      if (rd_err !== 1'b1) begin
         errors++;
         $display("FAIL rd_err_sticky: rd_err=%0b, required 1", rd_err);
      end
   endtask

   task automatic test_reset_mid_command();
      logic [AW+DW:0] e;
      logic [DW-1:0]  r;
      int             hs;
      for (int i = 0; i < 2; i++) cmdq.push_back({1'b0, 25'h0000300, 32'h0});
      vid_req = 1'b1; vid_addr = 25'h0000300; cmd_ready = 1'b1;
      hs = 0;
      for (int cyc = 0; cyc < 10 && hs < 2; cyc++) begin
         #1;
         if (cmd_valid && cmd_ready) begin
            hs++;
            checks++;
            e = cmdq.pop_front();
            if ({cmd_write, cmd_addr, cmd_wdata} !== e) begin
               errors++;
               $display("FAIL pre_reset_cmd: got %h, required %h", {cmd_write, cmd_addr, cmd_wdata}, e);
            end
         end
         tick();
      end
      cmd_ready = 1'b0;
      tick(); #1;
      checks++;
      if (hs != 2 || cmd_valid !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_issue: reads=%0d valid=%0b, required 2 1", hs, cmd_valid);
      end
      rst = 1'b1; cmd_ready = 1'b1; #1;
      checks++;
      if (cmd_valid !== 1'b0 || vid_ack !== 1'b0 || gfx_ack !== 1'b0 || rd_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_cmd: valid=%0b vid_ack=%0b gfx_ack=%0b err=%0b, required 0 0 0 0",
                  cmd_valid, vid_ack, gfx_ack, rd_err);
      end
      vid_req = 1'b0;
      tick(); rst = 1'b0; cmd_ready = 1'b0;
      tick();
      // outstanding must be 0 again: four reads fit
      for (int i = 0; i < 4; i++) cmdq.push_back({1'b0, 25'h0000380, 32'h0});
      vid_req = 1'b1; vid_addr = 25'h0000380; cmd_ready = 1'b1;
      hs = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         #1;
         if (cmd_valid && cmd_ready) begin
            hs++;
            checks++;
            if (cmdq.size() == 0) begin
               errors++;
               $display("FAIL post_reset_cmd: unexpected read addr=%h", cmd_addr);
            end else begin
               e = cmdq.pop_front();
               if ({cmd_write, cmd_addr, cmd_wdata} !== e) begin
                  errors++;
                  $display("FAIL post_reset_cmd: got %h, required %h", {cmd_write, cmd_addr, cmd_wdata}, e);
               end
            end
         end
         tick();
      end
      vid_req = 1'b0; cmd_ready = 1'b0;
      checks++;
      if (hs != 4) begin
         errors++;
         $display("FAIL post_reset_outstanding: reads=%0d, required 4", hs);
      end
      for (int i = 0; i < 4; i++) begin
         rd_valid = 1'b1; rd_data = 32'hC0000000 + 32'(i);
         rdq.push_back(rd_data);
         tick(); rd_valid = 1'b0; #1;
         checks++;
         r = rdq.pop_front();
         if (vid_rvalid !== 1'b1 || vid_rdata !== r) begin
            errors++;
            $display("FAIL post_reset_return[%0d]: rvalid=%0b rdata=%h, required 1 %h", i, vid_rvalid, vid_rdata, r);
         end
      end
      checks++;
      if (rd_err !== 1'b0 || cmdq.size() != 0 || rdq.size() != 0) begin
         errors++;
         $display("FAIL final_state: rd_err=%0b cmdq=%0d rdq=%0d, required 0 0 0", rd_err, cmdq.size(), rdq.size());
      end
   endtask

   initial begin
      test_reset();
      test_vid_basic();
      test_gfx_stall();
      test_streak();
      test_outstanding_limit();
      test_same_cycle_and_err();
      test_reset_mid_command();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
